// File: rtl/stim_gen_pkg.sv
// Shared types and LFSR tap table for the stim_gen address/data stimulus generator.
package stim_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Fibonacci tap masks: bit (k-1) set for each x^k term (maximal-length polynomials).
  function automatic logic [63:0] prbs_taps(input int unsigned width);
    case (width)
      8:       prbs_taps = 64'h0000_0000_0000_00B8;
      16:      prbs_taps = 64'h0000_0000_0000_D008;
      32:      prbs_taps = 64'h0000_0000_8020_0003;
      64:      prbs_taps = 64'hD800_0000_0000_0000;
      default: prbs_taps = 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/stim_gen_pattern.sv
// Combinational next-data generator for the four stim_gen data patterns.
module stim_gen_pattern
  import stim_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  mode_e                 mode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] next_data_c
);

  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(prbs_taps(DATA_WIDTH));

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("stim_gen_pattern: DATA_WIDTH must be 8, 16, 32 or 64");
  end

  always_comb begin
    next_data_c = data;
    case (mode)
      MODE_INC:   next_data_c = data + DATA_WIDTH'(1);
      MODE_PRBS:  next_data_c = {data[DATA_WIDTH-2:0], ^(data & TAPS)};
      MODE_CONST: next_data_c = data;
      MODE_WALK:  next_data_c = {data[DATA_WIDTH-2:0], data[DATA_WIDTH-1]};
      default:    next_data_c = data;
    endcase
  end

endmodule

// File: rtl/stim_gen.sv
// Burst address/data stimulus generator with valid/ready output stream.
// Optional running XOR signature output enabled by defining STIM_GEN_SIG_EN.
module stim_gen
  import stim_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef STIM_GEN_SIG_EN
  ,
  output logic [DATA_WIDTH-1:0] sig
`endif
);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic [DATA_WIDTH-1:0]   next_data_c;
  logic                    last_d, valid_d, busy_d, done_d;
  logic                    xfer_c;
`ifdef STIM_GEN_SIG_EN
  logic [DATA_WIDTH-1:0]   sig_d;
`endif

  stim_gen_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_pattern (
    .mode        (mode_q),
    .data        (out_data),
    .next_data_c (next_data_c)
  );

  assign xfer_c = out_valid && out_ready;

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_INC;
      stride_q  <= '0;
      rem_q     <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef STIM_GEN_SIG_EN
      sig       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      stride_q  <= stride_d;
      rem_q     <= rem_d;
      out_addr  <= addr_d;
      out_data  <= data_d;
      out_last  <= last_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef STIM_GEN_SIG_EN
      sig       <= sig_d;
`endif
    end
  end

  // Next-state and next-output logic; valid rises one cycle after entering RUN.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    addr_d   = out_addr;
    data_d   = out_data;
    last_d   = out_last;
    valid_d  = 1'b0;
    done_d   = 1'b0;
`ifdef STIM_GEN_SIG_EN
    sig_d    = sig;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d   = mode_e'(mode);
          stride_d = stride;
          rem_d    = burst_len;
          addr_d   = base_addr;
          last_d   = (burst_len == LEN_WIDTH'(1));
          case (mode_e'(mode))
            MODE_PRBS: data_d = (seed == '0) ? DATA_WIDTH'(1) : seed;
            MODE_WALK: data_d = DATA_WIDTH'(1);
            default:   data_d = seed;
          endcase
`ifdef STIM_GEN_SIG_EN
          sig_d    = '0;
`endif
          state_d  = (burst_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        valid_d = 1'b1;
        if (xfer_c) begin
          addr_d = out_addr + stride_q;
          data_d = next_data_c;
          rem_d  = rem_q - LEN_WIDTH'(1);
          last_d = (rem_q == LEN_WIDTH'(2));
`ifdef STIM_GEN_SIG_EN
          sig_d  = sig ^ out_data;
`endif
          if (out_last) begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

endmodule

// File: tb/tb_stim_gen.sv
// Randomized self-checking bench for stim_gen against a burst-level reference model.
module tb_stim_gen;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;
  localparam logic [DW-1:0] TAPS = 32'h8020_0003;  // x^32+x^22+x^2+x+1

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr, stride;
  logic [LW-1:0] burst_len;
  logic [DW-1:0] seed;
  logic          out_valid, out_last, busy, done;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
`ifdef STIM_GEN_SIG_EN
  logic [DW-1:0] sig;
`endif

  always #5 sys_clk = ~sys_clk;

  stim_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .mode(mode),
    .base_addr(base_addr), .stride(stride), .burst_len(burst_len), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
`ifdef STIM_GEN_SIG_EN
    , .sig(sig)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the whole burst is precomputed, timing is expressed as cycle offsets.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] cap_a[$];
  logic [DW-1:0] cap_d[$];
  bit            active = 1'b0;
  bit            chk_en = 1'b0;
  int            cyc = 0;
  int            s_cyc = 0;
  int            done_due = -1;
  int            dut_xfers = 0;
  int            rdy_mode = 0;
  logic [DW-1:0] sig_m = '0;

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
    return {s[DW-2:0], ^(s & TAPS)};
  endfunction

  function automatic void plan(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW-1:0] st,
                               input logic [LW-1:0] len, input logic [DW-1:0] sd);
    logic [DW-1:0] p;
    beat_t         bt;
    int            n;
    n = int'(len);
    p = (sd == '0) ? DW'(1) : sd;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      bt.a = b + AW'(i) * st;
      case (m)
        2'd0:    bt.d = sd + DW'(i);
        2'd1:    bt.d = p;
        2'd2:    bt.d = sd;
        default: bt.d = DW'(1) << (i % DW);
      endcase
      bt.l = (i == n - 1);
      exp_q.push_back(bt);
      p = lfsr_step(p);
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge sys_clk) begin : cmp
    logic ev, eb;
    cyc++;
    if (chk_en) begin
      ev = active && (cyc >= s_cyc + 2) && (exp_q.size() > 0);
      eb = active && (cyc >= s_cyc + 1) && (exp_q.size() > 0);
      check("out_valid", 64'(out_valid), 64'(ev));
      check("busy", 64'(busy), 64'(eb));
      check("done", 64'(done), 64'(cyc == done_due));
      if (ev) begin
        check("out_addr", 64'(out_addr), 64'(exp_q[0].a));
        check("out_data", 64'(out_data), 64'(exp_q[0].d));
        check("out_last", 64'(out_last), 64'(exp_q[0].l));
      end
`ifdef STIM_GEN_SIG_EN
      check("sig", 64'(sig), 64'(sig_m));
`endif
      if (out_valid && out_ready) begin
        dut_xfers++;
        cap_a.push_back(out_addr);
        cap_d.push_back(out_data);
      end
      if (cyc == done_due) active = 1'b0;
      if (ev && out_ready) begin
        sig_m ^= exp_q[0].d;
        if (exp_q.size() == 1) done_due = cyc + 2;
        void'(exp_q.pop_front());
      end
      if (start && !active) begin
        plan(mode, base_addr, stride, burst_len, seed);
        active = 1'b1;
        s_cyc  = cyc;
        sig_m  = '0;
        if (burst_len == '0) done_due = cyc + 2;
      end
    end
  end

  always @(posedge sys_clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && active; i++) @(negedge sys_clk);
    check("burst_timeout", 64'(active), 64'(0));
    if (active) begin
      active = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW-1:0] st,
                             input logic [LW-1:0] len, input logic [DW-1:0] sd);
    @(posedge sys_clk); #1;
    mode = m; base_addr = b; stride = st; burst_len = len; seed = sd; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    mode = 2'($urandom); stride = $urandom; base_addr = $urandom;
    burst_len = LW'($urandom); seed = $urandom;
  endtask

  task automatic run_burst(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW-1:0] st,
                           input logic [LW-1:0] len, input logic [DW-1:0] sd, input int rm);
    rdy_mode = rm;
    cap_a.delete();
    cap_d.delete();
    pulse_start(m, b, st, len, sd);
    wait_idle(4 * int'(len) + 40);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_addr"}, 64'(out_addr), 64'(0));
    check({tag, "_data"}, 64'(out_data), 64'(0));
    check({tag, "_last"}, 64'(out_last), 64'(0));
  endtask

  initial begin
    int n0;
    start = 1'b0; mode = '0; base_addr = '0; stride = '0; burst_len = '0; seed = '0;
    #2 sys_rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    chk_en = 1'b1;

    check("model_lfsr_1", 64'(lfsr_step(32'd1)), 64'h3);
    check("model_lfsr_3", 64'(lfsr_step(32'd3)), 64'h6);

    // INC reference burst
    run_burst(2'd0, 32'h100, 32'd4, 16'd4, 32'h10, 0);
    check("inc_count", 64'(cap_a.size()), 64'd4);
    for (int i = 0; i < 4 && i < cap_a.size(); i++) begin
      check("inc_addr_lit", 64'(cap_a[i]), 64'(32'h100 + 32'(4 * i)));
      check("inc_data_lit", 64'(cap_d[i]), 64'(32'h10 + 32'(i)));
    end

    // WALK with toggling ready, wrapping past the MSB
    run_burst(2'd3, 32'h2000, 32'd8, 16'd34, 32'hDEAD_BEEF, 1);
    check("walk_count", 64'(cap_d.size()), 64'd34);
    if (cap_d.size() == 34) begin
      check("walk_msb_lit", 64'(cap_d[31]), 64'h8000_0000);
      check("walk_wrap_lit", 64'(cap_d[32]), 64'h1);
    end

    // PRBS from zero seed, random backpressure
    run_burst(2'd1, 32'h0, 32'd1, 16'd1000, 32'h0, 2);
    check("prbs_count", 64'(cap_d.size()), 64'd1000);
    if (cap_d.size() > 2) begin
      check("prbs_first_lit", 64'(cap_d[0]), 64'h1);
      check("prbs_third_lit", 64'(cap_d[2]), 64'h6);
    end

    // Zero-length burst
    run_burst(2'd0, 32'h40, 32'd4, 16'd0, 32'h7, 0);
    check("len0_count", 64'(cap_d.size()), 64'd0);

    // start during RUN is ignored
    rdy_mode = 1;
    n0 = dut_xfers;
    pulse_start(2'd0, 32'h500, 32'd2, 16'd6, 32'h55);
    repeat (3) @(posedge sys_clk);
    #1 start = 1'b1; burst_len = 16'd9; mode = 2'd2;
    @(posedge sys_clk); #1 start = 1'b0;
    wait_idle(60);
    check("ignored_start_count", 64'(dut_xfers - n0), 64'd6);

    // Address wrap
    run_burst(2'd2, 32'h1, 32'hFFFF_FFFF, 16'd3, 32'h9, 0);
    if (cap_a.size() == 3) begin
      check("wrap_a0_lit", 64'(cap_a[0]), 64'h1);
      check("wrap_a1_lit", 64'(cap_a[1]), 64'h0);
      check("wrap_a2_lit", 64'(cap_a[2]), 64'hFFFF_FFFF);
    end else check("wrap_count", 64'(cap_a.size()), 64'd3);

    // CONST signature cases
    run_burst(2'd2, 32'h0, 32'd1, 16'd3, 32'hA5, 2);
`ifdef STIM_GEN_SIG_EN
    check("sig_odd_lit", 64'(sig), 64'hA5);
`endif
    run_burst(2'd2, 32'h0, 32'd1, 16'd4, 32'hA5, 2);
`ifdef STIM_GEN_SIG_EN
    check("sig_even_lit", 64'(sig), 64'h0);
`endif

    // Randomized bursts
    for (int k = 0; k < 25; k++)
      run_burst(2'($urandom), $urandom, $urandom, LW'($urandom_range(0, 20)), $urandom,
                int'($urandom_range(0, 2)));

    // Reset in the middle of a burst
    rdy_mode = 0;
    pulse_start(2'd0, 32'h800, 32'd4, 16'd50, 32'h1);
    repeat (8) @(posedge sys_clk);
    #2 chk_en = 1'b0;
    sys_rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    active = 1'b0; exp_q.delete(); done_due = -1; sig_m = '0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(posedge sys_clk);
    run_burst(2'd1, 32'h30, 32'd16, 16'd12, 32'h1234_5678, 2);
    check("post_reset_count", 64'(cap_d.size()), 64'd12);

    repeat (3) @(posedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stim_gen.md
Name: stim_gen

Overview:
- Synthesizable, parametrised address/data stimulus generator for simulation benches and on-chip self-test.
- Starts a burst of beats on a `start` pulse; each beat carries an address and a data word.
- Address advances by a programmable stride. Data follows one of four patterns: increment, PRBS (LFSR), constant, walking-one.
- Beats leave on a valid/ready stream interface with a `last` marker, and the burst signals `done` on completion.

Parameters:
- DATA_WIDTH, 32, data word width; legal values 8, 16, 32, 64.
- ADDR_WIDTH, 32, address width, any value >= 1.
- LEN_WIDTH, 16, width of the burst-length field.

Ports:
- sys_clk  in  1  single clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  burst request; sampled in IDLE only.
- mode  in  2  0=INC, 1=PRBS, 2=CONST, 3=WALK.
- base_addr  in  ADDR_WIDTH  first beat address.
- stride  in  ADDR_WIDTH  address increment per beat.
- burst_len  in  LEN_WIDTH  beats per burst.
- seed  in  DATA_WIDTH  initial data value.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts beat.
- out_addr  out  ADDR_WIDTH  beat address.
- out_data  out  DATA_WIDTH  beat data.
- out_last  out  1  final beat of burst.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: one clock (sys_clk); reset is asynchronous and active-low (sys_rst_n). Assertion forces the FSM to IDLE immediately, including mid-burst. All outputs and internal registers go to 0; no `done` pulse is produced for the aborted burst.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - When `start`=1, latch `mode`, `stride` and `burst_len`; set `out_addr`=`base_addr`.
  - Initial `out_data` by mode: INC and CONST use `seed`. PRBS uses `seed`, replaced by 1 if `seed`==0. WALK uses 1 (`seed` ignored).
  - If `burst_len`==0, go to DONE; otherwise go to RUN with `remaining`=`burst_len`.
- Latency: `start` sampled at edge N gives `out_valid`=1 after edge N+1. `busy`=1 in RUN only.
- RUN:
  - `out_valid`=1 throughout.
  - A beat transfers on any edge where `out_valid`&&`out_ready`.
  - While `out_ready`=0, `out_addr`, `out_data` and `out_last` hold stable.
  - `out_last`=1 exactly when `remaining`==1.
- On each transfer:
  - `out_addr` += latched stride, mod 2^ADDR_WIDTH (silent wrap).
  - `remaining` decrements by 1.
  - INC: data+1, mod 2^DATA_WIDTH.
  - PRBS: Fibonacci LFSR, shift left, feedback into bit 0 = XOR of tap bits from the package mask. The taps give a maximal-length sequence, so the all-zero state is never reached.
  - CONST: data unchanged.
  - WALK: rotate left by 1; MSB wraps to bit 0.
- Final transfer (`out_last`=1): go to DONE; `out_valid` drops after that edge.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored in RUN and DONE (no queuing).
- Back-to-back bursts: the earliest next `start` is the cycle after DONE.
- `mode` and `stride` changes during RUN have no effect, since they are latched at start.

Optional Feature:
- Macro: STIM_GEN_SIG_EN.
- Defined: adds output port `sig` (DATA_WIDTH).
  - `sig` is cleared to 0 when a burst starts.
  - Each transfer does `sig` ^= `out_data`.
  - `sig` holds its value through DONE and IDLE until the next start; reset value 0.
- Undefined: `sig` port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `stim_gen_pkg` holds:
  - mode enum (INC, PRBS, CONST, WALK);
  - FSM state enum;
  - function `prbs_taps(width)` returning tap masks: 8 -> x^8+x^6+x^5+x^4+1, 16 -> x^16+x^15+x^13+x^4+1, 32 -> x^32+x^22+x^2+x+1, 64 -> x^64+x^63+x^61+x^60+1. Any other width is an elaboration error.
- Sub-module `stim_gen_pattern`: combinational next-data for the current mode (INC/PRBS/CONST/WALK). The top holds the FSM, address/length counters, handshake and signature.

Test Plan:
- INC, `base_addr`=0x100, `stride`=4, `burst_len`=4, `seed`=0x10, `out_ready`=1 -> addr 0x100/0x104/0x108/0x10C, data 0x10..0x13; `out_last` on 4th beat; `done` one cycle later.
- WALK, DATA_WIDTH=8, `burst_len`=10, `out_ready` toggling 1/0 each cycle -> data 0x01,0x02,…,0x80,0x01,0x02. Outputs stable while `out_ready`=0; exactly 10 transfers.
- PRBS, `seed`=0, DATA_WIDTH=32 -> first beat data 1; sequence matches reference LFSR model for 1000 beats and never reaches 0.
- `burst_len`=0 -> `out_valid` stays 0; `done` pulses 2 edges after `start`. `start` asserted during RUN of another burst -> ignored, beat count unchanged.
- `stride`=0xFFFFFFFF, `base_addr`=1, `burst_len`=3 -> addr 1, 0, 0xFFFFFFFF (wrap). Deassert `sys_rst_n` mid-burst -> all outputs 0 immediately, no `done`; new `start` after release runs cleanly.
- With STIM_GEN_SIG_EN, CONST `seed`=0xA5 (8-bit), `burst_len`=3 -> `sig`=0xA5 after burst; `burst_len`=4 -> `sig`=0x00.
